// File: rtl/uart_time_msg_sched.sv
// rtl/uart_time_msg_sched.sv - formats BCD time snapshots as "HH:MM:SS\r\n" and paces bytes into uart_tx
module uart_time_msg_sched #(
    parameter int CLK_FREQ  = 24000000,
    parameter int UART_BPS  = 115200,
    parameter int GAP_EXTRA = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       time_vld,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       dropped
);
    localparam int PERIOD       = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYCLES = 10 * PERIOD + GAP_EXTRA;
    localparam int TW           = $clog2(FRAME_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [23:0]     act_q, act_d;
    logic [23:0]     pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dropped_q, dropped_d;
    logic [23:0]     snap;

    function automatic logic [7:0] ascii_digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [23:0] t, input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = ascii_digit(t[23:20]);
            4'd1:    b = ascii_digit(t[19:16]);
            4'd3:    b = ascii_digit(t[15:12]);
            4'd4:    b = ascii_digit(t[11:8]);
            4'd6:    b = ascii_digit(t[7:4]);
            4'd7:    b = ascii_digit(t[3:0]);
            4'd8:    b = 8'h0D;
            4'd9:    b = 8'h0A;
            default: b = 8'h3A;
        endcase
        return b;
    endfunction

    assign snap = {hour, min, sec};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dropped_d  = 1'b0;

        // While a message is in flight, snapshots go to the single pending slot
        if (time_vld && state_q != IDLE) begin
            pend_d     = snap;
            pend_vld_d = 1'b1;
            dropped_d  = pend_vld_q;
        end

        case (state_q)
            IDLE: begin
                if (pend_vld_q || time_vld) begin
                    act_d      = pend_vld_q ? pend_q : snap;
                    pend_vld_d = pend_vld_q && time_vld;
                    if (pend_vld_q && time_vld) begin
                        pend_d = snap;
                    end
                    state_d    = SEND;
                    idx_d      = 4'd0;
                    timer_d    = TIMER_LOAD;
                    tx_start_d = 1'b1;
                    tx_data_d  = msg_byte(pend_vld_q ? pend_q : snap, 4'd0);
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                timer_d = timer_q - 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (idx_q != 4'd9) begin
                    idx_d      = idx_q + 4'd1;
                    state_d    = SEND;
                    timer_d    = TIMER_LOAD;
                    tx_start_d = 1'b1;
                    tx_data_d  = msg_byte(act_q, idx_q + 4'd1);
                end else begin
                    // A pending snapshot keeps busy high across the done cycle
                    done_d  = 1'b1;
                    state_d = IDLE;
                    busy_d  = pend_vld_q || time_vld;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            timer_q    <= '0;
            act_q      <= 24'h0;
            pend_q     <= 24'h0;
            pend_vld_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dropped  = dropped_q;
endmodule
